// File: rtl/w_regfile.sv
// rtl/w_regfile.sv - Y86-style writeback register file with condition codes and retirement counter
module w_regfile #(
    parameter bit BYPASS = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        W_stall_i,
    input  logic        W_valid_i,
    input  logic [3:0]  W_dstE_i,
    input  logic [31:0] W_valE_i,
    input  logic [3:0]  W_dstM_i,
    input  logic [31:0] W_valM_i,
    input  logic [3:0]  d_srcA_i,
    input  logic [3:0]  d_srcB_i,
    output logic [31:0] d_rvalA_o,
    output logic [31:0] d_rvalB_o,
    input  logic        E_setcc_i,
    input  logic        e_zf_i,
    input  logic        e_sf_i,
    input  logic        e_of_i,
    output logic        cc_zf_o,
    output logic        cc_sf_o,
    output logic        cc_of_o,
    output logic [31:0] retired_o
);

    logic [31:0] regs [8];
    logic [31:0] retired_q;
    logic        cc_zf_q;
    logic        cc_sf_q;
    logic        cc_of_q;

    logic        wb_en;
    logic        e_we;
    logic        m_we;

    // IDs 8..15 (including RNONE) all have bit 3 set, so one bit decides legality.
    assign wb_en = W_valid_i & ~W_stall_i;
    assign e_we  = wb_en & ~W_dstE_i[3];
    assign m_we  = wb_en & ~W_dstM_i[3];

    // M-port is tested first so that popl %esp stores the popped value, not the incremented pointer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 8; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (m_we && (W_dstM_i == 4'(i))) begin
                    regs[i] <= W_valM_i;
                end else if (e_we && (W_dstE_i == 4'(i))) begin
                    regs[i] <= W_valE_i;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cc_zf_q <= 1'b1;
            cc_sf_q <= 1'b0;
            cc_of_q <= 1'b0;
        end else if (E_setcc_i && !W_stall_i) begin
            cc_zf_q <= e_zf_i;
            cc_sf_q <= e_sf_i;
            cc_of_q <= e_of_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            retired_q <= '0;
        end else if (wb_en) begin
            retired_q <= retired_q + 32'd1;
        end
    end

    // Bypass applies the same priority as the array write: M overrides E.
    function automatic logic [31:0] read_port(input logic [3:0] src);
        logic [31:0] val;
        val = src[3] ? 32'h0 : regs[src[2:0]];
        if (BYPASS && e_we && (src == W_dstE_i)) begin
            val = W_valE_i;
        end
        if (BYPASS && m_we && (src == W_dstM_i)) begin
            val = W_valM_i;
        end
        return val;
    endfunction

    assign d_rvalA_o = read_port(d_srcA_i);
    assign d_rvalB_o = read_port(d_srcB_i);
    assign cc_zf_o   = cc_zf_q;
    assign cc_sf_o   = cc_sf_q;
    assign cc_of_o   = cc_of_q;
    assign retired_o = retired_q;

endmodule

// File: tb/tb_w_regfile.sv
// tb/tb_w_regfile.sv - table-driven bench for w_regfile (bypass and non-bypass instances)
module tb_w_regfile;

    logic        clk;
    logic        rst;
    logic        W_stall_i;
    logic        W_valid_i;
    logic [3:0]  W_dstE_i;
    logic [31:0] W_valE_i;
    logic [3:0]  W_dstM_i;
    logic [31:0] W_valM_i;
    logic [3:0]  d_srcA_i;
    logic [3:0]  d_srcB_i;
    logic        E_setcc_i;
    logic        e_zf_i;
    logic        e_sf_i;
    logic        e_of_i;

    logic [31:0] d_rvalA_o;
    logic [31:0] d_rvalB_o;
    logic        cc_zf_o;
    logic        cc_sf_o;
    logic        cc_of_o;
    logic [31:0] retired_o;

    logic [31:0] nb_rvalA;
    logic [31:0] nb_rvalB;
    logic        nb_zf;
    logic        nb_sf;
    logic        nb_of;
    logic [31:0] nb_retired;

    int checks;
    int errors;

    w_regfile #(.BYPASS(1'b1)) dut (
        .clk(clk), .rst(rst), .W_stall_i(W_stall_i), .W_valid_i(W_valid_i),
        .W_dstE_i(W_dstE_i), .W_valE_i(W_valE_i), .W_dstM_i(W_dstM_i), .W_valM_i(W_valM_i),
        .d_srcA_i(d_srcA_i), .d_srcB_i(d_srcB_i), .d_rvalA_o(d_rvalA_o), .d_rvalB_o(d_rvalB_o),
        .E_setcc_i(E_setcc_i), .e_zf_i(e_zf_i), .e_sf_i(e_sf_i), .e_of_i(e_of_i),
        .cc_zf_o(cc_zf_o), .cc_sf_o(cc_sf_o), .cc_of_o(cc_of_o), .retired_o(retired_o)
    );

    w_regfile #(.BYPASS(1'b0)) dut_nb (
        .clk(clk), .rst(rst), .W_stall_i(W_stall_i), .W_valid_i(W_valid_i),
        .W_dstE_i(W_dstE_i), .W_valE_i(W_valE_i), .W_dstM_i(W_dstM_i), .W_valM_i(W_valM_i),
        .d_srcA_i(d_srcA_i), .d_srcB_i(d_srcB_i), .d_rvalA_o(nb_rvalA), .d_rvalB_o(nb_rvalB),
        .E_setcc_i(E_setcc_i), .e_zf_i(e_zf_i), .e_sf_i(e_sf_i), .e_of_i(e_of_i),
        .cc_zf_o(nb_zf), .cc_sf_o(nb_sf), .cc_of_o(nb_of), .retired_o(nb_retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic        stall;
        logic [3:0]  dst_e;
        logic [31:0] val_e;
        logic [3:0]  dst_m;
        logic [31:0] val_m;
        logic [3:0]  src_a;
        logic [3:0]  src_b;
        logic        setcc;
        logic [2:0]  flags;      // {zf, sf, of} driven
        logic [31:0] exp_a;      // bypass instance, before the edge
        logic [31:0] exp_b;
        logic [31:0] exp_nb_a;   // non-bypass instance, before the edge
        logic [2:0]  exp_cc;     // {zf, sf, of} after the edge
        logic [31:0] exp_ret;    // after the edge
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        W_stall_i = 1'b0;
        W_valid_i = 1'b0;
        W_dstE_i  = 4'hF;
        W_valE_i  = '0;
        W_dstM_i  = 4'hF;
        W_valM_i  = '0;
        E_setcc_i = 1'b0;
        e_zf_i    = 1'b0;
        e_sf_i    = 1'b0;
        e_of_i    = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0;
        d_srcA_i = 4'h0;
        d_srcB_i = 4'h0;
        drive_idle();

        //          vld  stl  dE     valE          dM     valM          sA     sB     scc  flags   expA          expB          expNbA        cc      ret
        vecs[0]  = '{1'b1,1'b0,4'h0, 32'h12345678, 4'hF, 32'h0,        4'h0, 4'h1, 1'b0,3'b000, 32'h12345678, 32'h0,        32'h0,        3'b100, 32'd1};
        vecs[1]  = '{1'b0,1'b0,4'hF, 32'h0,        4'hF, 32'h0,        4'h0, 4'hF, 1'b1,3'b011, 32'h12345678, 32'h0,        32'h12345678, 3'b011, 32'd1};
        vecs[2]  = '{1'b1,1'b0,4'h4, 32'h100,      4'h4, 32'h200,      4'h4, 4'h0, 1'b0,3'b100, 32'h200,      32'h12345678, 32'h0,        3'b011, 32'd2};
        vecs[3]  = '{1'b0,1'b0,4'hF, 32'h0,        4'hF, 32'h0,        4'h4, 4'h4, 1'b0,3'b000, 32'h200,      32'h200,      32'h200,      3'b011, 32'd2};
        vecs[4]  = '{1'b1,1'b1,4'h1, 32'hAAAA,     4'h2, 32'hBBBB,     4'h1, 4'h2, 1'b1,3'b100, 32'h0,        32'h0,        32'h0,        3'b011, 32'd2};
        vecs[5]  = '{1'b0,1'b0,4'hF, 32'h0,        4'hF, 32'h0,        4'h1, 4'h2, 1'b0,3'b000, 32'h0,        32'h0,        32'h0,        3'b011, 32'd2};
        vecs[6]  = '{1'b1,1'b0,4'hA, 32'h5555,     4'hF, 32'h6666,     4'hA, 4'hF, 1'b0,3'b000, 32'h0,        32'h0,        32'h0,        3'b011, 32'd3};
        vecs[7]  = '{1'b0,1'b0,4'hF, 32'h0,        4'hF, 32'h0,        4'h9, 4'hF, 1'b0,3'b000, 32'h0,        32'h0,        32'h0,        3'b011, 32'd3};
        vecs[8]  = '{1'b0,1'b0,4'hF, 32'h0,        4'hF, 32'h0,        4'h0, 4'h4, 1'b1,3'b110, 32'h12345678, 32'h200,      32'h12345678, 3'b110, 32'd3};
        vecs[9]  = '{1'b1,1'b0,4'h3, 32'h33,       4'h7, 32'h77,       4'h3, 4'h7, 1'b0,3'b000, 32'h33,       32'h77,       32'h0,        3'b110, 32'd4};
        vecs[10] = '{1'b0,1'b0,4'hF, 32'h0,        4'hF, 32'h0,        4'h7, 4'h3, 1'b0,3'b000, 32'h77,       32'h33,       32'h77,       3'b110, 32'd4};
        vecs[11] = '{1'b1,1'b0,4'hF, 32'h0,        4'hF, 32'h0,        4'h5, 4'h6, 1'b0,3'b000, 32'h0,        32'h0,        32'h0,        3'b110, 32'd5};

        // Reset state
        repeat (2) @(negedge clk);
        check("reset_retired", retired_o, 32'd0);
        check("reset_cc", {29'd0, cc_zf_o, cc_sf_o, cc_of_o}, 32'h4);
        for (int r = 0; r < 8; r++) begin
            d_srcA_i = 4'(r);
            #1;
            check($sformatf("reset_reg%0d", r), d_rvalA_o, 32'h0);
        end
        rst = 1'b1;

        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            W_valid_i = vecs[i].valid;
            W_stall_i = vecs[i].stall;
            W_dstE_i  = vecs[i].dst_e;
            W_valE_i  = vecs[i].val_e;
            W_dstM_i  = vecs[i].dst_m;
            W_valM_i  = vecs[i].val_m;
            d_srcA_i  = vecs[i].src_a;
            d_srcB_i  = vecs[i].src_b;
            E_setcc_i = vecs[i].setcc;
            {e_zf_i, e_sf_i, e_of_i} = vecs[i].flags;
            #1;
            check($sformatf("v%0d_rvalA", i), d_rvalA_o, vecs[i].exp_a);
            check($sformatf("v%0d_rvalB", i), d_rvalB_o, vecs[i].exp_b);
            check($sformatf("v%0d_nb_rvalA", i), nb_rvalA, vecs[i].exp_nb_a);
            @(posedge clk);
            #1;
            check($sformatf("v%0d_cc", i), {29'd0, cc_zf_o, cc_sf_o, cc_of_o}, {29'd0, vecs[i].exp_cc});
            check($sformatf("v%0d_retired", i), retired_o, vecs[i].exp_ret);
        end

        // Counter wrap from all-ones
        @(negedge clk);
        drive_idle();
        force dut.retired_q = 32'hFFFF_FFFF;
        #1;
        release dut.retired_q;
        #1;
        check("wrap_preload", retired_o, 32'hFFFF_FFFF);
        W_valid_i = 1'b1;
        @(posedge clk);
        #1;
        check("wrap_zero", retired_o, 32'h0);

        // Write ebx and clear zf, then reset between edges
        @(negedge clk);
        drive_idle();
        W_valid_i = 1'b1;
        W_dstE_i  = 4'h3;
        W_valE_i  = 32'hDEAD_BEEF;
        E_setcc_i = 1'b1;
        {e_zf_i, e_sf_i, e_of_i} = 3'b011;
        @(posedge clk);
        #1;
        drive_idle();
        d_srcA_i = 4'h3;
        d_srcB_i = 4'h5;
        #1;
        check("ebx_written", d_rvalA_o, 32'hDEAD_BEEF);
        check("zf_cleared", {31'd0, cc_zf_o}, 32'h0);

        @(negedge clk);
        #2;
        W_valid_i = 1'b1;
        W_dstE_i  = 4'h5;
        W_valE_i  = 32'h1111;
        rst = 1'b0;
        #1;
        check("rst_async_ebx", d_rvalA_o, 32'h0);
        check("rst_async_cc", {29'd0, cc_zf_o, cc_sf_o, cc_of_o}, 32'h4);
        check("rst_async_retired", retired_o, 32'h0);
        check("rst_bypass", d_rvalB_o, 32'h1111);
        @(posedge clk);
        #1;
        @(negedge clk);
        drive_idle();
        #1;
        check("rst_write_discarded", d_rvalB_o, 32'h0);
        check("rst_count_discarded", retired_o, 32'h0);
        rst = 1'b1;
        W_valid_i = 1'b1;
        W_dstE_i  = 4'h5;
        W_valE_i  = 32'h2222;
        @(posedge clk);
        #1;
        drive_idle();
        #1;
        check("post_rst_write", d_rvalB_o, 32'h2222);
        check("post_rst_retired", retired_o, 32'd1);
        check("post_rst_nb_write", nb_rvalB, 32'h2222);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
